spi_ready_sync: RTL and testbench
=================================

SPI_READY_SYNC -- requirements
Module: spi_ready_sync

Interface
REQ-001 Parameter SYNC_STAGES, default 2, meaning synchronizer flops per ready flag; legal range 2..3.
REQ-002 Parameter FIFO_DEPTH, default 4, meaning spike-byte FIFO entries; power of two, legal range 2..16.
REQ-003 clk  input  1  system clock; every register in the block is clocked on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 clk_div_ready_in  input  1  level flag from the SPI clock domain; asynchronous to clk.
REQ-006 input_spike_ready_in  input  1  level flag from the SPI clock domain; asynchronous to clk.
REQ-007 debug_config_ready_in  input  1  level flag from the SPI clock domain; asynchronous to clk.
REQ-008 clk_div_cfg_in  input  8  clock-divider byte; stable while clk_div_ready_in is high.
REQ-009 spike_byte_in  input  8  input-spike byte; stable while input_spike_ready_in is high.
REQ-010 debug_cfg_in  input  8  debug configuration byte; stable while debug_config_ready_in is high.
REQ-011 clk_div_value  output  8  latched divider value.
REQ-012 clk_div_update  output  1  one-cycle pulse marking a new clk_div_value.
REQ-013 spike_data  output  8  FIFO head byte; valid only while spike_valid is high.
REQ-014 spike_valid  output  1  FIFO is not empty.
REQ-015 spike_ready  input  1  consumer accepts the head byte when spike_valid and spike_ready are both high.
REQ-016 spike_overflow  output  1  sticky flag: a spike byte was dropped.
REQ-017 overflow_clr  input  1  clears spike_overflow.
REQ-018 debug_cfg  output  8  latched debug byte.
REQ-019 debug_update  output  1  one-cycle pulse marking a new debug_cfg value.

Function
REQ-020 Each *_ready_in flag shall pass through its own SYNC_STAGES-flop synchronizer chain.
REQ-021 A rising edge of a synchronized flag shall be detected by comparing the last synchronizer stage with one extra delay flop, producing an event on exactly one cycle.
  - A flag that stays high gives no further events.
  - A flag must fall and rise again to give a new event.
REQ-022 On a clk_div event, clk_div_value shall load clk_div_cfg_in and clk_div_update shall be high on the next cycle only.
  - Latency from the input flag rising to the pulse is SYNC_STAGES+2 cycles.
REQ-023 On a spike event, spike_byte_in shall be written into the FIFO in the same cycle, unless the FIFO is full.
REQ-024 A write to a full FIFO shall be dropped and shall set spike_overflow.
  - A write in the same cycle as a pop from a full FIFO shall be accepted, not dropped.
REQ-025 A pop (spike_valid and spike_ready both high) shall advance the read pointer.
  - A pop on an empty FIFO has no effect.
REQ-026 A write and a pop in the same cycle shall leave the occupancy unchanged.
REQ-027 The FIFO pointers shall be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
  - Full: the pointers differ only in the MSB.
  - Empty: the pointers are equal.
REQ-028 spike_data shall be a combinational read of the head entry.
  - A write into an empty FIFO makes spike_valid high on the cycle after the write.
REQ-029 overflow_clr shall clear spike_overflow; if a drop happens in the same cycle, set wins.
REQ-030 Events on different flags in the same cycle shall each be processed independently in that cycle.

Reset
REQ-031 While reset_n is low at a clk edge, the following shall be cleared to 0:
  - all synchronizer and edge-detect flops;
  - FIFO pointers and spike_overflow;
  - clk_div_value, clk_div_update, debug_cfg and debug_update.
REQ-032 FIFO storage contents are not reset; spike_valid shall read 0 on the cycle after reset.
REQ-033 A flag already high when reset is released shall produce one event once it has propagated through the synchronizer.
REQ-034 Reset during a pending event shall discard the event.

Configuration
REQ-035 With macro SPI_READY_SYNC_DEBUG_EN defined, the debug_config_ready_in synchronizer, debug_cfg and debug_update shall be implemented as in REQ-020/021/022, with debug_cfg_in as the data source.
REQ-036 With SPI_READY_SYNC_DEBUG_EN undefined, debug_cfg shall be tied to 8'h00 and debug_update to 0.
  - No debug flops are inferred.
  - The ports remain present.

Verification
REQ-037 Reset test: hold reset_n low 3 cycles, then release -> all outputs are 0 and spike_valid is 0.
REQ-038 Divider update: clk_div_cfg_in=8'h2A, then raise clk_div_ready_in and hold it -> clk_div_value=8'h2A and exactly one clk_div_update pulse, 4 cycles after the flag rises with SYNC_STAGES=2.
REQ-039 FIFO fill and drain, with spike_ready=0:
  - Stimulus: 4 spike events with bytes 01,02,03,04, then a 5th with byte 05.
  - Required: spike_overflow=1.
  - Then spike_ready=1: pops return 01,02,03,04 in order, then spike_valid=0.
REQ-040 Simultaneous write and pop on a full FIFO: FIFO full and spike_ready=1 while a spike event occurs -> occupancy stays 4, spike_overflow stays 0, and the new byte is returned last.
REQ-041 overflow_clr and a drop in the same cycle -> spike_overflow remains 1.
  - On the next clear with no drop, it reads 0.
REQ-042 Debug path, build with and without SPI_READY_SYNC_DEBUG_EN, debug_cfg_in=8'hA5, then raise debug_config_ready_in:
  - Defined: debug_cfg=8'hA5 with one debug_update pulse.
  - Undefined: debug_cfg=8'h00 and debug_update stays 0.

Source files
------------

// File: rtl/spi_ready_sync.sv
// Brings three SPI-domain ready flags into clk, latching divider/debug bytes and queueing spike bytes.
// Optional debug path is built only when SPI_READY_SYNC_DEBUG_EN is defined.
module spi_ready_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_div_ready_in,
  input  logic       input_spike_ready_in,
  input  logic       debug_config_ready_in,
  input  logic [7:0] clk_div_cfg_in,
  input  logic [7:0] spike_byte_in,
  input  logic [7:0] debug_cfg_in,
  output logic [7:0] clk_div_value,
  output logic       clk_div_update,
  output logic [7:0] spike_data,
  output logic       spike_valid,
  input  logic       spike_ready,
  output logic       spike_overflow,
  input  logic       overflow_clr,
  output logic [7:0] debug_cfg,
  output logic       debug_update
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam int F_DIV = 0;
  localparam int F_SPK = 1;
`ifdef SPI_READY_SYNC_DEBUG_EN
  localparam int F_DBG = 2;
  localparam int NF    = 3;
`else
  localparam int NF    = 2;
`endif

  logic [NF-1:0] flag_in;
  logic [NF-1:0] flag_evt;

  assign flag_in[F_DIV] = clk_div_ready_in;
  assign flag_in[F_SPK] = input_spike_ready_in;
`ifdef SPI_READY_SYNC_DEBUG_EN
  assign flag_in[F_DBG] = debug_config_ready_in;
`endif

  // Per-flag synchronizer plus one delay flop for rising-edge detection.
  genvar gi;
  generate
    for (gi = 0; gi < NF; gi++) begin : gen_sync
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   last_reg;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          sync_reg <= '0;
          last_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], flag_in[gi]};
          last_reg <= sync_reg[SYNC_STAGES-1];
        end
      end

      assign flag_evt[gi] = sync_reg[SYNC_STAGES-1] & ~last_reg;
    end
  endgenerate

  logic [7:0] clk_div_value_reg;
  logic       clk_div_update_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_div_value_reg  <= 8'h00;
      clk_div_update_reg <= 1'b0;
    end else begin
      clk_div_update_reg <= flag_evt[F_DIV];
      if (flag_evt[F_DIV])
        clk_div_value_reg <= clk_div_cfg_in;
    end
  end

  assign clk_div_value  = clk_div_value_reg;
  assign clk_div_update = clk_div_update_reg;

  logic [7:0]  mem_reg [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0] rd_ptr_reg, rd_ptr_next;
  logic        overflow_reg, overflow_next;
  logic        fifo_empty, fifo_full, pop, wr_en, drop;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop        = ~fifo_empty & spike_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign wr_en      = flag_evt[F_SPK] & (~fifo_full | pop);
  assign drop       = flag_evt[F_SPK] & fifo_full & ~pop;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    overflow_next = overflow_reg;
    if (wr_en)
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    if (pop)
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    if (drop)
      overflow_next = 1'b1;
    else if (overflow_clr)
      overflow_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      overflow_reg <= overflow_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && wr_en)
      mem_reg[wr_ptr_reg[AW-1:0]] <= spike_byte_in;
  end

  assign spike_data     = mem_reg[rd_ptr_reg[AW-1:0]];
  assign spike_valid    = ~fifo_empty;
  assign spike_overflow = overflow_reg;

`ifdef SPI_READY_SYNC_DEBUG_EN
  logic [7:0] debug_cfg_reg;
  logic       debug_update_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      debug_cfg_reg    <= 8'h00;
      debug_update_reg <= 1'b0;
    end else begin
      debug_update_reg <= flag_evt[F_DBG];
      if (flag_evt[F_DBG])
        debug_cfg_reg <= debug_cfg_in;
    end
  end

  assign debug_cfg    = debug_cfg_reg;
  assign debug_update = debug_update_reg;
`else
  logic unused_dbg;
  assign unused_dbg   = ^{debug_config_ready_in, debug_cfg_in};
  assign debug_cfg    = 8'h00;
  assign debug_update = 1'b0;
`endif

endmodule

// File: tb/tb_spi_ready_sync.sv
// Directed self-checking bench for spi_ready_sync (default parameters).
// Debug-path expectations follow SPI_READY_SYNC_DEBUG_EN.
module tb_spi_ready_sync;

  localparam int SYNC_STAGES = 2;
  localparam int FIFO_DEPTH  = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clk_div_ready_in, input_spike_ready_in, debug_config_ready_in;
  logic [7:0] clk_div_cfg_in, spike_byte_in, debug_cfg_in;
  logic [7:0] clk_div_value, spike_data, debug_cfg;
  logic       clk_div_update, spike_valid, spike_ready;
  logic       spike_overflow, overflow_clr, debug_update;

  int checks = 0;
  int errors = 0;

  spi_ready_sync #(.SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .clk_div_ready_in      (clk_div_ready_in),
    .input_spike_ready_in  (input_spike_ready_in),
    .debug_config_ready_in (debug_config_ready_in),
    .clk_div_cfg_in        (clk_div_cfg_in),
    .spike_byte_in         (spike_byte_in),
    .debug_cfg_in          (debug_cfg_in),
    .clk_div_value         (clk_div_value),
    .clk_div_update        (clk_div_update),
    .spike_data            (spike_data),
    .spike_valid           (spike_valid),
    .spike_ready           (spike_ready),
    .spike_overflow        (spike_overflow),
    .overflow_clr          (overflow_clr),
    .debug_cfg             (debug_cfg),
    .debug_update          (debug_update)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise the spike flag; the event cycle starts two edges later and the write lands on the third.
  task automatic push(input logic [7:0] b, input logic pop_at_write, input logic clr_at_write);
    spike_byte_in        = b;
    input_spike_ready_in = 1'b1;
    step();
    step();
    spike_ready  = pop_at_write;
    overflow_clr = clr_at_write;
    step();
    spike_ready  = 1'b0;
    overflow_clr = 1'b0;
    step();
    input_spike_ready_in = 1'b0;
    repeat (4) step();
  endtask

  task automatic drain(input string tag, input logic [7:0] first);
    spike_ready = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      check($sformatf("%s_valid%0d", tag, i), spike_valid, 1'b1);
      check($sformatf("%s_data%0d", tag, i), spike_data, first + 8'(i));
      step();
    end
    check($sformatf("%s_empty", tag), spike_valid, 1'b0);
    spike_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    int pulses;
    logic [7:0] exp_dbg;
    logic [31:0] exp_dbg_pulses;

    reset_n = 1'b0;
    clk_div_ready_in = 1'b0; input_spike_ready_in = 1'b0; debug_config_ready_in = 1'b0;
    clk_div_cfg_in = 8'h00; spike_byte_in = 8'h00; debug_cfg_in = 8'h00;
    spike_ready = 1'b0; overflow_clr = 1'b0;

    repeat (3) step();
    reset_n = 1'b1;
    check("rst_div_value", clk_div_value, 8'h00);
    check("rst_div_update", clk_div_update, 1'b0);
    check("rst_spike_valid", spike_valid, 1'b0);
    check("rst_overflow", spike_overflow, 1'b0);
    check("rst_debug_cfg", debug_cfg, 8'h00);
    check("rst_debug_update", debug_update, 1'b0);
    repeat (2) step();

    // Divider: the cycle the flag is raised is cycle 1; the pulse must be in cycle SYNC_STAGES+2.
    clk_div_cfg_in   = 8'h2A;
    clk_div_ready_in = 1'b1;
    cyc = 1;
    while (clk_div_update !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    check("div_latency", cyc, SYNC_STAGES + 2);
    check("div_value", clk_div_value, 8'h2A);
    pulses = 0;
    repeat (10) begin
      step();
      if (clk_div_update === 1'b1) pulses++;
    end
    check("div_extra_pulses", pulses, 0);
    clk_div_ready_in = 1'b0;
    repeat (5) step();

    // Fill to full, then one more to overflow, then drain in order.
    push(8'h01, 1'b0, 1'b0);
    check("fill_first_valid", spike_valid, 1'b1);
    check("fill_first_data", spike_data, 8'h01);
    push(8'h02, 1'b0, 1'b0);
    push(8'h03, 1'b0, 1'b0);
    push(8'h04, 1'b0, 1'b0);
    check("full_no_overflow", spike_overflow, 1'b0);
    push(8'h05, 1'b0, 1'b0);
    check("overflow_set", spike_overflow, 1'b1);
    drain("drain1", 8'h01);

    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    check("overflow_cleared", spike_overflow, 1'b0);

    // Pop on empty has no effect.
    spike_ready = 1'b1;
    repeat (3) step();
    spike_ready = 1'b0;
    check("pop_empty_valid", spike_valid, 1'b0);

    // Write coinciding with a pop on a full FIFO is accepted; new byte comes out last.
    push(8'h11, 1'b0, 1'b0);
    push(8'h12, 1'b0, 1'b0);
    push(8'h13, 1'b0, 1'b0);
    push(8'h14, 1'b0, 1'b0);
    push(8'h15, 1'b1, 1'b0);
    check("wrpop_no_overflow", spike_overflow, 1'b0);
    drain("drain2", 8'h12);

    // Drop and clear in the same cycle: set wins; a later plain clear works.
    push(8'h21, 1'b0, 1'b0);
    push(8'h22, 1'b0, 1'b0);
    push(8'h23, 1'b0, 1'b0);
    push(8'h24, 1'b0, 1'b0);
    push(8'h25, 1'b0, 1'b1);
    check("drop_vs_clr", spike_overflow, 1'b1);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    check("clr_no_drop", spike_overflow, 1'b0);
    drain("drain3", 8'h21);

    // Debug and divider flags rising together are handled independently.
`ifdef SPI_READY_SYNC_DEBUG_EN
    exp_dbg = 8'hA5;
    exp_dbg_pulses = 1;
`else
    exp_dbg = 8'h00;
    exp_dbg_pulses = 0;
`endif
    debug_cfg_in          = 8'hA5;
    clk_div_cfg_in        = 8'h3C;
    debug_config_ready_in = 1'b1;
    clk_div_ready_in      = 1'b1;
    pulses = 0;
    cyc = 0;
    repeat (10) begin
      step();
      if (debug_update === 1'b1) pulses++;
      if (clk_div_update === 1'b1) cyc++;
    end
    check("dbg_cfg", debug_cfg, exp_dbg);
    check("dbg_pulses", pulses, exp_dbg_pulses);
    check("div2_value", clk_div_value, 8'h3C);
    check("div2_pulses", cyc, 1);
    debug_config_ready_in = 1'b0;
    clk_div_ready_in      = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
